// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 subordinate backed by a word-organised memory, with independent
// write and read burst engines (FIXED/INCR/WRAP, byte strobes, SLVERR on illegal/out-of-range beats).
module axi_mem_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    axi_ACLK,
    input  logic                    axi_ARESET,
    input  logic                    axi_AWVALID,
    output logic                    axi_AWREADY,
    input  logic [ID_WIDTH-1:0]     axi_AWID,
    input  logic [ADDR_WIDTH-1:0]   axi_AWADDR,
    input  logic [LEN_WIDTH-1:0]    axi_AWLEN,
    input  logic [2:0]              axi_AWSIZE,
    input  logic [1:0]              axi_AWBURST,
    input  logic                    axi_WVALID,
    output logic                    axi_WREADY,
    input  logic [DATA_WIDTH-1:0]   axi_WDATA,
    input  logic [DATA_WIDTH/8-1:0] axi_WSTRB,
    input  logic                    axi_WLAST,
    output logic                    axi_BVALID,
    input  logic                    axi_BREADY,
    output logic [ID_WIDTH-1:0]     axi_BID,
    output logic [1:0]              axi_BRESP,
    input  logic                    axi_ARVALID,
    output logic                    axi_ARREADY,
    input  logic [ID_WIDTH-1:0]     axi_ARID,
    input  logic [ADDR_WIDTH-1:0]   axi_ARADDR,
    input  logic [LEN_WIDTH-1:0]    axi_ARLEN,
    input  logic [2:0]              axi_ARSIZE,
    input  logic [1:0]              axi_ARBURST,
    output logic                    axi_RVALID,
    input  logic                    axi_RREADY,
    output logic [ID_WIDTH-1:0]     axi_RID,
    output logic [DATA_WIDTH-1:0]   axi_RDATA,
    output logic [1:0]              axi_RRESP,
    output logic                    axi_RLAST
);
    localparam int SW  = DATA_WIDTH / 8;
    localparam int OFS = $clog2(SW);
    localparam int IW  = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
            input logic [LEN_WIDTH-1:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] bytes, mask;
        bytes = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        return burst == 2'b00 ? a : burst == 2'b10 ? (a & ~mask) | ((a + bytes) & mask) : a + bytes;
    endfunction

    function automatic logic bad_burst(input logic [LEN_WIDTH-1:0] len, input logic [2:0] size,
            input logic [1:0] burst);
        return 32'(size) > OFS || burst == 2'b11 || (burst == 2'b10 &&
            !(len == LEN_WIDTH'(1) || len == LEN_WIDTH'(3) || len == LEN_WIDTH'(7) || len == LEN_WIDTH'(15)));
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a >> OFS) < MEM_DEPTH;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic live;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [ADDR_WIDTH-1:0] w_addr, r_addr, f_addr;
    logic [LEN_WIDTH-1:0] w_len, w_cnt, r_len, r_cnt, f_len, f_cnt;
    logic [2:0] w_size, r_size, f_size;
    logic [1:0] w_burst, r_burst, f_burst;
    logic [ID_WIDTH-1:0] w_id;
    logic w_bad, w_err, r_bad, f_bad, f_err;
    logic aw_fire, w_fire, ar_fire, r_fetch;

    assign aw_fire = axi_AWVALID && axi_AWREADY;
    assign w_fire  = axi_WVALID && axi_WREADY;
    assign ar_fire = axi_ARVALID && axi_ARREADY;
    assign r_fetch = ar_fire || (axi_RVALID && axi_RREADY && !axi_RLAST);

    // Holds the address-channel READYs low for the cycle following any reset edge.
    always_ff @(posedge axi_ACLK) live <= !axi_ARESET;

    always_ff @(posedge axi_ACLK) begin
        w_state <= axi_ARESET ? W_IDLE : w_next;
        r_state <= axi_ARESET ? R_IDLE : r_next;
    end

    always_comb begin
        w_next = (w_state == W_IDLE && aw_fire) ? W_DATA :
                 (w_state == W_DATA && w_fire && w_cnt == w_len) ? W_RESP :
                 (w_state == W_RESP && axi_BREADY) ? W_IDLE : w_state;
        r_next = (r_state == R_IDLE && ar_fire) ? R_DATA :
                 (r_state == R_DATA && axi_RREADY && axi_RLAST) ? R_IDLE : r_state;
    end

    always_comb begin
        axi_AWREADY = live && w_state == W_IDLE;
        axi_WREADY  = w_state == W_DATA;
        axi_BVALID  = w_state == W_RESP;
        axi_BID     = w_state == W_RESP ? w_id : '0;
        axi_BRESP   = (w_state == W_RESP && w_err) ? 2'b10 : 2'b00;
        axi_ARREADY = live && r_state == R_IDLE;
        axi_RVALID  = r_state == R_DATA;
    end

    always_ff @(posedge axi_ACLK) begin
        if (aw_fire) begin
            w_addr  <= axi_AWADDR;
            w_len   <= axi_AWLEN;
            w_size  <= axi_AWSIZE;
            w_burst <= axi_AWBURST;
            w_id    <= axi_AWID;
            w_cnt   <= '0;
            w_bad   <= bad_burst(axi_AWLEN, axi_AWSIZE, axi_AWBURST);
            w_err   <= bad_burst(axi_AWLEN, axi_AWSIZE, axi_AWBURST);
        end else if (w_fire) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt + LEN_WIDTH'(1);
            w_err  <= w_err || !in_range(w_addr) || (axi_WLAST != (w_cnt == w_len));
        end
    end

    always_ff @(posedge axi_ACLK) begin
        if (!axi_ARESET && w_fire && !w_bad && in_range(w_addr))
            for (int i = 0; i < SW; i++)
                if (axi_WSTRB[i]) mem[IW'(w_addr >> OFS)][8*i +: 8] <= axi_WDATA[8*i +: 8];
    end

    // Beat fetch uses either the fresh AR request or the stored next-beat state.
    always_comb begin
        f_addr  = ar_fire ? axi_ARADDR : r_addr;
        f_len   = ar_fire ? axi_ARLEN : r_len;
        f_size  = ar_fire ? axi_ARSIZE : r_size;
        f_burst = ar_fire ? axi_ARBURST : r_burst;
        f_bad   = ar_fire ? bad_burst(axi_ARLEN, axi_ARSIZE, axi_ARBURST) : r_bad;
        f_cnt   = ar_fire ? '0 : r_cnt + LEN_WIDTH'(1);
        f_err   = f_bad || !in_range(f_addr);
    end

    always_ff @(posedge axi_ACLK) begin
        if (axi_ARESET) begin
            axi_RDATA <= '0;
            axi_RRESP <= 2'b00;
            axi_RLAST <= 1'b0;
            axi_RID   <= '0;
        end else if (r_fetch) begin
            axi_RDATA <= f_err ? '0 : mem[IW'(f_addr >> OFS)];
            axi_RRESP <= f_err ? 2'b10 : 2'b00;
            axi_RLAST <= f_cnt == f_len;
            r_addr    <= next_addr(f_addr, f_len, f_size, f_burst);
            r_cnt     <= f_cnt;
            r_len     <= f_len;
            r_size    <= f_size;
            r_burst   <= f_burst;
            r_bad     <= f_bad;
            if (ar_fire) axi_RID <= axi_ARID;
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed bench for axi_mem_responder with hand-computed expectations.
module tb_axi_mem_responder;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic clk = 1'b0;
    logic axi_ARESET;
    logic axi_AWVALID, axi_AWREADY, axi_WVALID, axi_WREADY, axi_WLAST;
    logic [3:0] axi_AWID, axi_ARID, axi_BID, axi_RID, axi_WSTRB;
    logic [15:0] axi_AWADDR, axi_ARADDR;
    logic [7:0] axi_AWLEN, axi_ARLEN;
    logic [2:0] axi_AWSIZE, axi_ARSIZE;
    logic [1:0] axi_AWBURST, axi_ARBURST, axi_BRESP, axi_RRESP;
    logic [31:0] axi_WDATA, axi_RDATA;
    logic axi_BVALID, axi_BREADY, axi_ARVALID, axi_ARREADY, axi_RVALID, axi_RREADY, axi_RLAST;

    int tests = 0;
    int fails = 0;
    logic [31:0] wd [16];
    logic [31:0] r_data [16];
    logic [1:0] r_resp [16];
    logic r_last [16];
    logic [3:0] r_id [16];

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .axi_ACLK(clk), .axi_ARESET(axi_ARESET),
        .axi_AWVALID(axi_AWVALID), .axi_AWREADY(axi_AWREADY), .axi_AWID(axi_AWID),
        .axi_AWADDR(axi_AWADDR), .axi_AWLEN(axi_AWLEN), .axi_AWSIZE(axi_AWSIZE), .axi_AWBURST(axi_AWBURST),
        .axi_WVALID(axi_WVALID), .axi_WREADY(axi_WREADY), .axi_WDATA(axi_WDATA), .axi_WSTRB(axi_WSTRB),
        .axi_WLAST(axi_WLAST),
        .axi_BVALID(axi_BVALID), .axi_BREADY(axi_BREADY), .axi_BID(axi_BID), .axi_BRESP(axi_BRESP),
        .axi_ARVALID(axi_ARVALID), .axi_ARREADY(axi_ARREADY), .axi_ARID(axi_ARID),
        .axi_ARADDR(axi_ARADDR), .axi_ARLEN(axi_ARLEN), .axi_ARSIZE(axi_ARSIZE), .axi_ARBURST(axi_ARBURST),
        .axi_RVALID(axi_RVALID), .axi_RREADY(axi_RREADY), .axi_RID(axi_RID), .axi_RDATA(axi_RDATA),
        .axi_RRESP(axi_RRESP), .axi_RLAST(axi_RLAST)
    );

    task automatic aw_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
            input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        axi_AWVALID = 1; axi_AWID = id; axi_AWADDR = addr; axi_AWLEN = len; axi_AWSIZE = size; axi_AWBURST = burst;
        while (!axi_AWREADY && t < 50) begin @(negedge clk); t++; end
        if (t == 50) begin tests++; fails++; $display("FAIL aw_timeout: AWREADY got 0 expected 1"); end
        @(negedge clk);
        axi_AWVALID = 0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
            input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        axi_ARVALID = 1; axi_ARID = id; axi_ARADDR = addr; axi_ARLEN = len; axi_ARSIZE = size; axi_ARBURST = burst;
        while (!axi_ARREADY && t < 50) begin @(negedge clk); t++; end
        if (t == 50) begin tests++; fails++; $display("FAIL ar_timeout: ARREADY got 0 expected 1"); end
        @(negedge clk);
        axi_ARVALID = 0;
    endtask

    task automatic w_send(input int n, input int last_at, input logic [3:0] strb);
        int t;
        for (int i = 0; i < n; i++) begin
            axi_WVALID = 1; axi_WDATA = wd[i]; axi_WSTRB = strb; axi_WLAST = (i == last_at);
            t = 0;
            while (!axi_WREADY && t < 50) begin @(negedge clk); t++; end
            if (t == 50) begin tests++; fails++; $display("FAIL w_timeout: WREADY got 0 expected 1 beat %0d", i); end
            @(negedge clk);
        end
        axi_WVALID = 0; axi_WLAST = 0;
    endtask

    task automatic b_recv(output logic [3:0] id, output logic [1:0] resp);
        int t = 0;
        axi_BREADY = 1;
        while (!axi_BVALID && t < 50) begin @(negedge clk); t++; end
        if (t == 50) begin tests++; fails++; $display("FAIL b_timeout: BVALID got 0 expected 1"); end
        id = axi_BID; resp = axi_BRESP;
        @(negedge clk);
        axi_BREADY = 0;
    endtask

    task automatic r_recv(input int n, input int stall, output int got);
        int t = 0;
        logic [39:0] snap;
        got = 0;
        axi_RREADY = 1;
        while (got < n && t < 200) begin
            t++;
            if (axi_RVALID) begin
                r_data[got] = axi_RDATA; r_resp[got] = axi_RRESP; r_last[got] = axi_RLAST; r_id[got] = axi_RID;
                got++;
                @(negedge clk);
                if (got == stall) begin
                    axi_RREADY = 0;
                    snap = {axi_RVALID, axi_RDATA, axi_RRESP, axi_RLAST, axi_RID};
                    tests++;
                    if (snap[39] !== 1'b1) begin fails++; $display("FAIL stall_valid: got %b expected 1", snap[39]); end
                    repeat (3) begin
                        @(negedge clk);
                        tests++;
                        if ({axi_RVALID, axi_RDATA, axi_RRESP, axi_RLAST, axi_RID} !== snap) begin
                            fails++;
                            $display("FAIL stall_hold: got %h expected %h", {axi_RVALID, axi_RDATA, axi_RRESP, axi_RLAST, axi_RID}, snap);
                        end
                    end
                    axi_RREADY = 1;
                end
            end else @(negedge clk);
        end
        axi_RREADY = 0;
        if (got < n) begin tests++; fails++; $display("FAIL r_timeout: beats got %0d expected %0d", got, n); end
    endtask

    task automatic wr(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
            input logic [1:0] burst, input int n, input int last_at, input logic [3:0] strb,
            output logic [3:0] bid, output logic [1:0] bresp);
        aw_send(id, addr, len, size, burst);
        w_send(n, last_at, strb);
        b_recv(bid, bresp);
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
            input logic [2:0] size, input logic [1:0] burst, input int n, output int got);
        ar_send(id, addr, len, size, burst);
        r_recv(n, 0, got);
    endtask

    task automatic test_reset();
        axi_ARESET = 1;
        axi_AWVALID = 0; axi_AWID = 0; axi_AWADDR = 0; axi_AWLEN = 0; axi_AWSIZE = 0; axi_AWBURST = 0;
        axi_WVALID = 0; axi_WDATA = 0; axi_WSTRB = 0; axi_WLAST = 0; axi_BREADY = 0;
        axi_ARVALID = 0; axi_ARID = 0; axi_ARADDR = 0; axi_ARLEN = 0; axi_ARSIZE = 0; axi_ARBURST = 0; axi_RREADY = 0;
        repeat (2) @(negedge clk);
        tests++;
        if ({axi_AWREADY, axi_WREADY, axi_ARREADY} !== 3'b000) begin
            fails++; $display("FAIL reset_ready: got %b expected 000", {axi_AWREADY, axi_WREADY, axi_ARREADY});
        end
        tests++;
        if ({axi_BVALID, axi_RVALID, axi_RLAST} !== 3'b000) begin
            fails++; $display("FAIL reset_valid: got %b expected 000", {axi_BVALID, axi_RVALID, axi_RLAST});
        end
        tests++;
        if ({axi_BID, axi_RID, axi_BRESP, axi_RRESP, axi_RDATA} !== 44'h0) begin
            fails++; $display("FAIL reset_fields: got %h expected 0", {axi_BID, axi_RID, axi_BRESP, axi_RRESP, axi_RDATA});
        end
        axi_ARESET = 0;
        @(negedge clk);
        tests++;
        if ({axi_AWREADY, axi_ARREADY} !== 2'b11) begin
            fails++; $display("FAIL post_reset_ready: got %b expected 11", {axi_AWREADY, axi_ARREADY});
        end
    endtask

    task automatic test_incr();
        logic [3:0] bid; logic [1:0] bresp; int got;
        for (int i = 0; i < 8; i++) wd[i] = 32'hA000_0000 + 32'(i) * 32'h0000_0101;
        wr(4'hA, 16'h0000, 8'd7, 3'd2, INCR, 8, 7, 4'hF, bid, bresp);
        tests++;
        if ({bid, bresp} !== {4'hA, 2'b00}) begin fails++; $display("FAIL incr_b: got %h/%b expected a/00", bid, bresp); end
        ar_send(4'h3, 16'h0000, 8'd7, 3'd2, INCR);
        tests++;
        if (axi_RVALID !== 1'b1) begin fails++; $display("FAIL incr_latency: RVALID got %b expected 1", axi_RVALID); end
        r_recv(8, 0, got);
        for (int i = 0; i < got; i++) begin
            tests++;
            if (r_data[i] !== 32'hA000_0000 + 32'(i) * 32'h0000_0101) begin
                fails++; $display("FAIL incr_data beat %0d: got %h expected %h", i, r_data[i], 32'hA000_0000 + 32'(i) * 32'h0000_0101);
            end
            tests++;
            if ({r_resp[i], r_last[i], r_id[i]} !== {2'b00, i == 7, 4'h3}) begin
                fails++; $display("FAIL incr_ctl beat %0d: got %b/%b/%h expected 00/%b/3", i, r_resp[i], r_last[i], r_id[i], i == 7);
            end
        end
    endtask

    task automatic test_strobe();
        logic [3:0] bid; logic [1:0] bresp, bresp2; int got;
        wd[0] = 32'h1122_3344;
        wr(4'h1, 16'h0010, 8'd0, 3'd2, INCR, 1, 0, 4'hF, bid, bresp);
        wd[0] = 32'hAABB_CCDD;
        wr(4'h1, 16'h0010, 8'd0, 3'd2, INCR, 1, 0, 4'b0101, bid, bresp2);
        tests++;
        if ({bresp, bresp2} !== 4'b0000) begin fails++; $display("FAIL strobe_b: got %b expected 0000", {bresp, bresp2}); end
        rd_burst(4'h1, 16'h0010, 8'd0, 3'd2, INCR, 1, got);
        tests++;
        if (r_data[0] !== 32'h11BB_33DD) begin fails++; $display("FAIL strobe_data: got %h expected 11bb33dd", r_data[0]); end
        tests++;
        if ({r_resp[0], r_last[0]} !== 3'b001) begin fails++; $display("FAIL strobe_ctl: got %b expected 001", {r_resp[0], r_last[0]}); end
    endtask

    task automatic test_range();
        logic [3:0] bid; logic [1:0] bresp; int got;
        for (int i = 0; i < 8; i++) wd[i] = 32'hBEEF_0000 + 32'(i);
        wr(4'h5, 16'h03F8, 8'd7, 3'd2, INCR, 8, 7, 4'hF, bid, bresp);
        tests++;
        if ({bid, bresp} !== {4'h5, 2'b10}) begin fails++; $display("FAIL range_b: got %h/%b expected 5/10", bid, bresp); end
        rd_burst(4'h6, 16'h03F8, 8'd7, 3'd2, INCR, 8, got);
        for (int i = 0; i < got; i++) begin
            tests++;
            if ({r_data[i], r_resp[i], r_last[i]} !== {(i < 2) ? 32'hBEEF_0000 + 32'(i) : 32'h0, (i < 2) ? 2'b00 : 2'b10, i == 7}) begin
                fails++; $display("FAIL range_beat %0d: got %h/%b/%b", i, r_data[i], r_resp[i], r_last[i]);
            end
        end
        rd_burst(4'h0, 16'h0000, 8'd0, 3'd2, INCR, 1, got);
        tests++;
        if (r_data[0] !== 32'hA000_0000) begin fails++; $display("FAIL range_alias: got %h expected a0000000", r_data[0]); end
        wd[0] = 32'h0; wd[1] = 32'h1;
        wr(4'h2, 16'h0040, 8'd1, 3'd2, INCR, 2, 0, 4'hF, bid, bresp);
        tests++;
        if (bresp !== 2'b10) begin fails++; $display("FAIL wlast_err: got %b expected 10", bresp); end
    endtask

    task automatic test_wrap();
        logic [3:0] bid; logic [1:0] bresp; int got;
        for (int i = 0; i < 4; i++) wd[i] = 32'hC0DE_0000 + 32'(i);
        wr(4'h7, 16'h0028, 8'd3, 3'd2, WRAP, 4, 3, 4'hF, bid, bresp);
        tests++;
        if (bresp !== 2'b00) begin fails++; $display("FAIL wrap_b: got %b expected 00", bresp); end
        rd_burst(4'h7, 16'h0020, 8'd3, 3'd2, INCR, 4, got);
        for (int i = 0; i < got; i++) begin
            tests++;
            if (r_data[i] !== 32'hC0DE_0000 + 32'((i + 2) % 4)) begin
                fails++; $display("FAIL wrap_layout %0d: got %h expected %h", i, r_data[i], 32'hC0DE_0000 + 32'((i + 2) % 4));
            end
        end
        rd_burst(4'h7, 16'h0028, 8'd3, 3'd2, WRAP, 4, got);
        for (int i = 0; i < got; i++) begin
            tests++;
            if ({r_data[i], r_resp[i]} !== {32'hC0DE_0000 + 32'(i), 2'b00}) begin
                fails++; $display("FAIL wrap_read %0d: got %h/%b expected %h/00", i, r_data[i], r_resp[i], 32'hC0DE_0000 + 32'(i));
            end
        end
        for (int i = 0; i < 3; i++) wd[i] = 32'hDEAD_0000 + 32'(i);
        wr(4'h8, 16'h0020, 8'd2, 3'd2, WRAP, 3, 2, 4'hF, bid, bresp);
        tests++;
        if (bresp !== 2'b10) begin fails++; $display("FAIL wrap_bad_b: got %b expected 10", bresp); end
        rd_burst(4'h8, 16'h0020, 8'd3, 3'd2, INCR, 4, got);
        for (int i = 0; i < got; i++) begin
            tests++;
            if (r_data[i] !== 32'hC0DE_0000 + 32'((i + 2) % 4)) begin
                fails++; $display("FAIL wrap_bad_nowrite %0d: got %h expected %h", i, r_data[i], 32'hC0DE_0000 + 32'((i + 2) % 4));
            end
        end
        rd_burst(4'h8, 16'h0020, 8'd2, 3'd2, WRAP, 3, got);
        for (int i = 0; i < got; i++) begin
            tests++;
            if ({r_data[i], r_resp[i]} !== {32'h0, 2'b10}) begin
                fails++; $display("FAIL wrap_bad_read %0d: got %h/%b expected 0/10", i, r_data[i], r_resp[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0] bid; logic [1:0] bresp; int got;
        for (int i = 0; i < 8; i++) wd[i] = 32'h5000_0000 + 32'(i);
        wr(4'h4, 16'h0100, 8'd7, 3'd2, INCR, 8, 7, 4'hF, bid, bresp);
        for (int i = 0; i < 4; i++) wd[i] = 32'h7000_0000 + 32'(i);
        fork
            begin
                ar_send(4'hC, 16'h0100, 8'd7, 3'd2, INCR);
                r_recv(8, 3, got);
            end
            begin
                aw_send(4'h9, 16'h0200, 8'd3, 3'd2, INCR);
                w_send(4, 3, 4'hF);
                b_recv(bid, bresp);
            end
        join
        tests++;
        if (axi_RVALID !== 1'b0) begin fails++; $display("FAIL stall_extra: RVALID got %b expected 0", axi_RVALID); end
        for (int i = 0; i < got; i++) begin
            tests++;
            if ({r_data[i], r_last[i]} !== {32'h5000_0000 + 32'(i), i == 7}) begin
                fails++; $display("FAIL stall_beat %0d: got %h/%b expected %h", i, r_data[i], r_last[i], 32'h5000_0000 + 32'(i));
            end
        end
        tests++;
        if ({bid, bresp} !== {4'h9, 2'b00}) begin fails++; $display("FAIL stall_write_b: got %h/%b expected 9/00", bid, bresp); end
        rd_burst(4'h9, 16'h0200, 8'd3, 3'd2, INCR, 4, got);
        for (int i = 0; i < got; i++) begin
            tests++;
            if (r_data[i] !== 32'h7000_0000 + 32'(i)) begin
                fails++; $display("FAIL stall_write_data %0d: got %h expected %h", i, r_data[i], 32'h7000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0] bid; logic [1:0] bresp; int got;
        for (int i = 0; i < 8; i++) wd[i] = 32'h6600_0000 + 32'(i);
        aw_send(4'h2, 16'h0300, 8'd7, 3'd2, INCR);
        w_send(4, 7, 4'hF);
        axi_ARESET = 1;
        @(negedge clk);
        tests++;
        if ({axi_AWREADY, axi_WREADY, axi_ARREADY, axi_BVALID, axi_RVALID, axi_RLAST} !== 6'b0) begin
            fails++; $display("FAIL abort_ctl: got %b expected 000000",
                {axi_AWREADY, axi_WREADY, axi_ARREADY, axi_BVALID, axi_RVALID, axi_RLAST});
        end
        tests++;
        if ({axi_BID, axi_RID, axi_BRESP, axi_RRESP, axi_RDATA} !== 44'h0) begin
            fails++; $display("FAIL abort_fields: got %h expected 0", {axi_BID, axi_RID, axi_BRESP, axi_RRESP, axi_RDATA});
        end
        @(negedge clk);
        axi_ARESET = 0;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (axi_BVALID !== 1'b0) begin fails++; $display("FAIL abort_no_b: BVALID got %b expected 0", axi_BVALID); end
        end
        rd_burst(4'h2, 16'h0300, 8'd3, 3'd2, INCR, 4, got);
        for (int i = 0; i < got; i++) begin
            tests++;
            if (r_data[i] !== 32'h6600_0000 + 32'(i)) begin
                fails++; $display("FAIL abort_persist %0d: got %h expected %h", i, r_data[i], 32'h6600_0000 + 32'(i));
            end
        end
        wd[0] = 32'h1234_5678;
        wr(4'hE, 16'h0320, 8'd0, 3'd2, FIXED, 1, 0, 4'hF, bid, bresp);
        tests++;
        if ({bid, bresp} !== {4'hE, 2'b00}) begin fails++; $display("FAIL abort_new_b: got %h/%b expected e/00", bid, bresp); end
        rd_burst(4'hE, 16'h0320, 8'd0, 3'd2, FIXED, 1, got);
        tests++;
        if (r_data[0] !== 32'h1234_5678) begin fails++; $display("FAIL abort_new_data: got %h expected 12345678", r_data[0]); end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_strobe();
        test_range();
        test_wrap();
        test_stall();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
